// File: rtl/parking_pkg.sv
// rtl/parking_pkg.sv - shared types, constants and BCD helpers for the parking occupancy controller
//
// Purpose : gate FSM state encoding, display widths, decimal-point patterns,
//           and BCD increment/decrement helpers shared by the rtl/ files.
// Ports   : none (package)
// Config  : DEBOUNCE_EN is consumed by sensor_conditioner, not here.

package parking_pkg;

  localparam int BCD_W  = 4;
  localparam int DIGITS = 4;
  localparam int CNT_W  = 14;

  localparam logic [3:0] DP_OFF  = 4'b1111;
  localparam logic [3:0] DP_FULL = 4'b1110;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    EN1  = 3'd1,
    EN2  = 3'd2,
    EN3  = 3'd3,
    EX1  = 3'd4,
    EX2  = 3'd5,
    EX3  = 3'd6
  } state_t;

  typedef logic [DIGITS*BCD_W-1:0] bcd_t;

  // Ripple a +1 carry from the units digit upwards; a 9 wraps to 0 and passes the carry on.
  function automatic bcd_t bcd_inc(input bcd_t v);
    bcd_t             r;
    logic             c;
    logic [BCD_W-1:0] d;
    r = v;
    c = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      d = r[i*BCD_W +: BCD_W];
      if (c) begin
        if (d == 4'd9) begin
          d = 4'd0;
        end else begin
          d = d + 4'd1;
          c = 1'b0;
        end
      end
      r[i*BCD_W +: BCD_W] = d;
    end
    return r;
  endfunction

  // Ripple a -1 borrow from the units digit upwards; a 0 wraps to 9 and passes the borrow on.
  function automatic bcd_t bcd_dec(input bcd_t v);
    bcd_t             r;
    logic             b;
    logic [BCD_W-1:0] d;
    r = v;
    b = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      d = r[i*BCD_W +: BCD_W];
      if (b) begin
        if (d == 4'd0) begin
          d = 4'd9;
        end else begin
          d = d - 4'd1;
          b = 1'b0;
        end
      end
      r[i*BCD_W +: BCD_W] = d;
    end
    return r;
  endfunction

endpackage

// File: rtl/sensor_conditioner.sv
// rtl/sensor_conditioner.sv - 2-FF synchroniser with optional debounce filter for one gate beam
//
// Purpose : bring an asynchronous beam-blocked level into the clk domain and,
//           when DEBOUNCE_EN is defined, only pass a new level after 2^DB_BITS
//           consecutive equal synchronised samples.
// Ports   : clk_i   - system clock
//           rst_ni  - asynchronous reset, active-low
//           sens_i  - raw beam level (1 = blocked), asynchronous
//           level_o - conditioned level for the direction FSM
// Config  : DEBOUNCE_EN defined   -> latency 2 + 2^DB_BITS clk
//           DEBOUNCE_EN undefined -> latency 2 clk, DB_BITS has no effect

module sensor_conditioner #(
  parameter int DB_BITS = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sens_i,
  output logic level_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= sens_i;
      sync_q <= meta_q;
    end
  end

`ifdef DEBOUNCE_EN
  logic [DB_BITS-1:0] db_cnt_q, db_cnt_d;
  logic               filt_q, filt_d;

  // The counter tallies consecutive samples disagreeing with the filtered level;
  // any agreeing sample restarts it, so short glitches never get through.
  always_comb begin
    db_cnt_d = '0;
    filt_d   = filt_q;
    if (sync_q != filt_q) begin
      if (&db_cnt_q) begin
        filt_d = sync_q;
      end else begin
        db_cnt_d = db_cnt_q + DB_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      db_cnt_q <= '0;
      filt_q   <= 1'b0;
    end else begin
      db_cnt_q <= db_cnt_d;
      filt_q   <= filt_d;
    end
  end

  assign level_o = filt_q;
`else
  // DB_BITS only shapes the debounce build; this empty block keeps it referenced.
  if (DB_BITS < 1) begin : g_db_bits_unused
  end

  assign level_o = sync_q;
`endif

endmodule

// File: rtl/parking_occupancy_ctrl.sv
// rtl/parking_occupancy_ctrl.sv - two-beam gate direction decoder with BCD occupancy count and flags
//
// Purpose : decode car direction from beams A (outside) and B (inside), keep a
//           saturating 4-digit BCD occupancy count with a binary shadow, and
//           drive the seven-segment mux inputs plus full/empty lamps.
// Ports   : clk       - system clock
//           reset     - asynchronous reset, active-low
//           sens_a/b  - beam A/B blocked (1), asynchronous
//           hex3..0   - BCD digits thousands..units
//           dp        - decimal points, active-low (units lit when full)
//           full      - count == CAPACITY
//           empty     - count == 0
//           car_enter - one-cycle pulse per valid entry
//           car_exit  - one-cycle pulse per valid exit
//           err       - one-cycle pulse on entry at full or exit at empty
// Config  : DEBOUNCE_EN enables the debounce filter in sensor_conditioner.

module parking_occupancy_ctrl
  import parking_pkg::*;
#(
  parameter int CAPACITY = 100,
  parameter int DB_BITS  = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sens_a,
  input  logic       sens_b,
  output logic [3:0] hex3,
  output logic [3:0] hex2,
  output logic [3:0] hex1,
  output logic [3:0] hex0,
  output logic [3:0] dp,
  output logic       full,
  output logic       empty,
  output logic       car_enter,
  output logic       car_exit,
  output logic       err
);

  localparam logic [CNT_W-1:0] CAP_BIN = CNT_W'(CAPACITY);

  logic       a_lvl, b_lvl;
  logic [1:0] ab;

  sensor_conditioner #(.DB_BITS(DB_BITS)) u_cond_a (
    .clk_i   (clk),
    .rst_ni  (reset),
    .sens_i  (sens_a),
    .level_o (a_lvl)
  );

  sensor_conditioner #(.DB_BITS(DB_BITS)) u_cond_b (
    .clk_i   (clk),
    .rst_ni  (reset),
    .sens_i  (sens_b),
    .level_o (b_lvl)
  );

  assign ab = {a_lvl, b_lvl};

  state_t           state_q, state_d;
  logic             enter_d, exit_d;
  logic             car_enter_q, car_exit_q, err_q;
  bcd_t             bcd_q, bcd_d;
  logic [CNT_W-1:0] bin_q, bin_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;

  // A car must block A, then both, then only B, then clear (or the mirror for
  // exits). Any step back toward the start, or a clear beam mid-pass, drops to
  // IDLE or an earlier stage without a pulse.
  always_comb begin
    state_d = state_q;
    enter_d = 1'b0;
    exit_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (ab == 2'b10)      state_d = EN1;
        else if (ab == 2'b01) state_d = EX1;
      end
      EN1: begin
        if (ab == 2'b11)      state_d = EN2;
        else if (ab != 2'b10) state_d = IDLE;
      end
      EN2: begin
        case (ab)
          2'b01:   state_d = EN3;
          2'b10:   state_d = EN1;
          2'b00:   state_d = IDLE;
          default: state_d = EN2;
        endcase
      end
      EN3: begin
        case (ab)
          2'b00: begin
            state_d = IDLE;
            enter_d = 1'b1;
          end
          2'b11:   state_d = EN2;
          2'b10:   state_d = IDLE;
          default: state_d = EN3;
        endcase
      end
      EX1: begin
        if (ab == 2'b11)      state_d = EX2;
        else if (ab != 2'b01) state_d = IDLE;
      end
      EX2: begin
        case (ab)
          2'b10:   state_d = EX3;
          2'b01:   state_d = EX1;
          2'b00:   state_d = IDLE;
          default: state_d = EX2;
        endcase
      end
      EX3: begin
        case (ab)
          2'b00: begin
            state_d = IDLE;
            exit_d  = 1'b1;
          end
          2'b11:   state_d = EX2;
          2'b01:   state_d = IDLE;
          default: state_d = EX3;
        endcase
      end
      default: state_d = IDLE;
    endcase
  end

  // Count moves on the edge after the pulse; the saturation checks use the
  // registered flags, which already reflect the previous car.
  always_comb begin
    bcd_d = bcd_q;
    bin_d = bin_q;
    if (car_enter_q && !full_q) begin
      bcd_d = bcd_inc(bcd_q);
      bin_d = bin_q + CNT_W'(1);
    end else if (car_exit_q && !empty_q) begin
      bcd_d = bcd_dec(bcd_q);
      bin_d = bin_q - CNT_W'(1);
    end
    full_d  = (bin_d == CAP_BIN);
    empty_d = (bin_d == '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      car_enter_q <= 1'b0;
      car_exit_q  <= 1'b0;
      err_q       <= 1'b0;
      bcd_q       <= '0;
      bin_q       <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      car_enter_q <= enter_d;
      car_exit_q  <= exit_d;
      err_q       <= (enter_d && full_q) || (exit_d && empty_q);
      bcd_q       <= bcd_d;
      bin_q       <= bin_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
    end
  end

  assign hex3      = bcd_q[3*BCD_W +: BCD_W];
  assign hex2      = bcd_q[2*BCD_W +: BCD_W];
  assign hex1      = bcd_q[1*BCD_W +: BCD_W];
  assign hex0      = bcd_q[0*BCD_W +: BCD_W];
  assign dp        = full_q ? DP_FULL : DP_OFF;
  assign full      = full_q;
  assign empty     = empty_q;
  assign car_enter = car_enter_q;
  assign car_exit  = car_exit_q;
  assign err       = err_q;

endmodule
